box_painter: RTL
================

BOX_PAINTER -- requirements
Module: box_painter

Interface
REQ-001 SHALL have parameter BOX_W, default 3, box width in pixels (1..8).
REQ-002 SHALL have parameter BOX_H, default 3, box height in pixels (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, request queue entries (power of two, >=2).
REQ-004 SHALL have parameters X_MAX, default 159, and Y_MAX, default 119, the last visible column and row.
REQ-005 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port req_valid, input, 1, which marks the request fields as valid.
REQ-008 SHALL have port req_ready, output, 1, high when the queue is not full.
REQ-009 SHALL have ports req_x, input, 8; req_y, input, 7; and req_colour, input, 3, giving the top-left corner and fill colour.
REQ-010 SHALL have ports vga_x, output, 8; vga_y, output, 7; and vga_colour, output, 3, giving the pixel presented to the VGA adapter.
REQ-011 SHALL have port plot, output, 1, the VGA write enable.
REQ-012 SHALL have port busy, output, 1, high while a box is being drawn or the queue is non-empty.
REQ-013 SHALL have port box_done, output, 1, a one-cycle pulse after the final pixel of each box.

Function
REQ-014 SHALL accept a request on a cycle where req_valid and req_ready are both high.
REQ-015 SHALL derive req_ready from registered queue occupancy only (not from req_valid), so a request offered while full is not accepted and must be held by the upstream stage.
REQ-016 SHALL queue requests in FIFO order, with no loss or duplication across simultaneous push and pop.
REQ-017 SHALL use draw FSM states IDLE, LOAD, DRAW and DONE, with DONE returning to IDLE.
- IDLE -> LOAD when the queue is non-empty.
- LOAD pops one entry into the working registers and clears the column offset dx and row offset dy to 0.
- DRAW steps one pixel per cycle.
- DONE lasts one cycle and asserts box_done.
REQ-018 SHALL draw pixels in raster order within the box: dx increments fastest; on dx=BOX_W-1, dx wraps to 0 and dy increments; DRAW -> DONE after dx=BOX_W-1 and dy=BOX_H-1.
REQ-019 SHALL hold vga_x=x0+dx, vga_y=y0+dy and vga_colour=the working colour in DRAW, with all three registered.
REQ-020 SHALL compute coordinates one bit wider than the port (9-bit x, 8-bit y) and suppress plot when x0+dx>X_MAX or y0+dy>Y_MAX; a suppressed pixel still takes its cycle (no wrap-around onto the screen).
REQ-021 SHALL take exactly BOX_W*BOX_H DRAW cycles per box; plot is high only in DRAW for unclipped pixels.
REQ-022 SHALL have the following latency: a request accepted in cycle t into an empty queue with the FSM in IDLE gives the first plot in cycle t+3 and box_done in cycle t+3+BOX_W*BOX_H.
REQ-023 SHALL, when the queue is non-empty, go DONE -> IDLE -> LOAD, giving a fixed 3-cycle gap between boxes.
REQ-024 SHALL hold plot=0 and box_done=0 outside DRAW and DONE respectively.
REQ-025 SHALL hold vga_x, vga_y and vga_colour at their last values when not drawing.

Reset
REQ-026 SHALL, on reset high at a clock edge, set the FSM to IDLE, empty the queue, and set plot=0, box_done=0, busy=0, vga_x=0, vga_y=0 and vga_colour=0.
REQ-027 SHALL abandon a box in progress when reset is asserted mid-box, with no further plot after the reset edge.
REQ-028 SHALL hold req_ready=0 while reset is high.
REQ-029 SHALL drive req_ready=1 on the first cycle after reset deasserts.

Structure
REQ-030 SHALL place in the shared game package the coordinate widths (X_W=8, Y_W=7, COL_W=3), the colour constants (white 3'b111, black 3'b000) and the screen limits 159/119.
REQ-031 SHALL keep the FSM state encoding local to the module.
REQ-032 SHALL implement the queue as one sub-module, box_req_fifo (synchronous, parameterised width and depth, full/empty flags).

Verification
REQ-033 SHALL cover a single box: req (38,4,3'b111) into the idle block -> 9 plots at (38..40, 4..6) in raster order starting 3 cycles after acceptance, then box_done one cycle after the last plot.
REQ-034 SHALL cover a burst: 6 back-to-back requests (43,y) for y=7,10,16,28,34,40 with req_valid held -> req_ready drops after 4 are queued, and 54 plots occur in request order with 3-cycle gaps between boxes.
REQ-035 SHALL cover clipping: req (158,118,3'b010) -> only (158,118), (159,118), (158,119) and (159,119) are plotted; box_done still occurs 9 DRAW cycles later.
REQ-036 SHALL cover reset mid-box: reset asserted at the 5th DRAW cycle -> plot=0 from the next cycle, busy=0, queue empty, and a new request is drawn normally afterwards.
REQ-037 SHALL cover simultaneous push/pop: queue holding 3 entries, LOAD pops while a new request is accepted in the same cycle -> occupancy stays 3 and the order is preserved.
REQ-038 SHALL cover parameter override: BOX_W=1, BOX_H=1, req (0,0,3'b100) -> exactly one plot at (0,0).

Source files
------------

// File: rtl/box_painter_pkg.sv
// -----------------------------------------------------------------------------
// box_painter_pkg
// Shared game package: screen coordinate widths, colour constants, screen
// limits and the packed request record carried through the request queue.
// No ports (package).
// -----------------------------------------------------------------------------
package box_painter_pkg;

   localparam int X_W   = 8;
   localparam int Y_W   = 7;
   localparam int COL_W = 3;

   localparam logic [COL_W-1:0] COL_WHITE = 3'b111;
   localparam logic [COL_W-1:0] COL_BLACK = 3'b000;

   // Last visible column / row of the 160x120 screen.
   localparam int SCR_X_MAX = 159;
   localparam int SCR_Y_MAX = 119;

   // Width of the queue-occupancy debug field exported on the interface.
   localparam int DBG_CNT_W = 8;

   typedef struct packed {
      logic [X_W-1:0]   x;
      logic [Y_W-1:0]   y;
      logic [COL_W-1:0] colour;
   } req_t;

   localparam int REQ_W = $bits(req_t);

endpackage : box_painter_pkg

// File: rtl/box_painter_if.sv
// -----------------------------------------------------------------------------
// box_painter_if
// Bundles the box request handshake, the VGA pixel outputs, status flags and
// debug observability (FSM state, queue occupancy) of box_painter.
//
// Handshake: a request transfers on every rising clock edge where req_valid
// and req_ready are both high. req_ready depends only on registered queue
// occupancy (and reset), never on req_valid; an upstream stage offering a
// request while req_ready is low must hold req_x/req_y/req_colour stable with
// req_valid high until the transfer happens.
//
// Modports:
//   master : request source / pixel sink (drives req_*)
//   slave  : the painter (drives req_ready, vga_*, plot, busy, box_done, dbg_*)
// -----------------------------------------------------------------------------
interface box_painter_if;
   import box_painter_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic [X_W-1:0]       req_x;
   logic [Y_W-1:0]       req_y;
   logic [COL_W-1:0]     req_colour;

   logic [X_W-1:0]       vga_x;
   logic [Y_W-1:0]       vga_y;
   logic [COL_W-1:0]     vga_colour;
   logic                 plot;
   logic                 busy;
   logic                 box_done;

   logic [1:0]           dbg_state;
   logic [DBG_CNT_W-1:0] dbg_count;

   modport master (
      output req_valid, req_x, req_y, req_colour,
      input  req_ready, vga_x, vga_y, vga_colour, plot, busy, box_done,
             dbg_state, dbg_count
   );

   modport slave (
      input  req_valid, req_x, req_y, req_colour,
      output req_ready, vga_x, vga_y, vga_colour, plot, busy, box_done,
             dbg_state, dbg_count
   );

endinterface : box_painter_if

// File: rtl/box_req_fifo.sv
// -----------------------------------------------------------------------------
// box_req_fifo
// Synchronous FIFO holding pending box requests.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (empties the queue)
//   i_push      : write i_data (ignored when full)
//   i_data      : entry to write
//   i_pop       : discard head entry (ignored when empty)
//   o_data      : head entry (valid when !o_empty)
//   o_full      : DEPTH entries stored
//   o_empty     : no entries stored
//   o_count     : current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module box_req_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_push;
   logic w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   // Storage carries no reset; only the pointers and occupancy matter.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         // A simultaneous push and pop leaves the occupancy unchanged.
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : box_req_fifo

// File: rtl/box_painter.sv
// -----------------------------------------------------------------------------
// box_painter
// Queues box requests (top-left corner + colour) and paints each one as a
// BOX_W x BOX_H filled rectangle, one pixel per clock, in raster order,
// through a VGA adapter write port. Pixels beyond X_MAX/Y_MAX are skipped
// (plot held low) but still consume their cycle.
// Ports:
//   clk    : clock, all logic on the rising edge
//   reset  : synchronous active-high reset
//   bus    : box_painter_if.slave -- request handshake, vga_x/vga_y/vga_colour,
//            plot, busy, box_done, dbg_state (FSM), dbg_count (queue occupancy)
// Timing: a request accepted in cycle t into an idle, empty painter plots its
// first pixel in cycle t+3 and pulses box_done in cycle t+3+BOX_W*BOX_H.
// -----------------------------------------------------------------------------
module box_painter
   import box_painter_pkg::*;
#(
   parameter int BOX_W      = 3,
   parameter int BOX_H      = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int X_MAX      = SCR_X_MAX,
   parameter int Y_MAX      = SCR_Y_MAX
) (
   input  logic       clk,
   input  logic       reset,
   box_painter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DRAW = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int DW    = 3;                      // offsets span 0..7
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t           r_state;
   req_t             r_req;
   logic [DW-1:0]    r_dx;
   logic [DW-1:0]    r_dy;
   logic [X_W-1:0]   r_vga_x;
   logic [Y_W-1:0]   r_vga_y;
   logic [COL_W-1:0] r_vga_colour;
   logic             r_plot;
   logic             r_box_done;

   logic             w_push;
   logic             w_pop;
   logic [REQ_W-1:0] w_in_data;
   logic [REQ_W-1:0] w_head_data;
   req_t             w_head;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;

   logic             w_last_col;
   logic             w_last_row;
   logic [DW-1:0]    w_nx_dx;
   logic [DW-1:0]    w_nx_dy;
   req_t             w_src;
   logic [DW-1:0]    w_off_x;
   logic [DW-1:0]    w_off_y;
   logic [X_W:0]     w_px;
   logic [Y_W:0]     w_py;
   logic             w_vis;

   // ---------------------------------------------------------------- queue
   assign w_push    = bus.req_valid && bus.req_ready;
   assign w_pop     = (r_state == S_LOAD);
   assign w_in_data = {bus.req_x, bus.req_y, bus.req_colour};
   assign w_head    = req_t'(w_head_data);

   box_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_in_data),
      .i_pop   (w_pop),
      .o_data  (w_head_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // --------------------------------------------------------- pixel stepping
   assign w_last_col = (r_dx == DW'(BOX_W - 1));
   assign w_last_row = (r_dy == DW'(BOX_H - 1));
   assign w_nx_dx    = w_last_col ? '0 : r_dx + 1'b1;
   assign w_nx_dy    = w_last_col ? r_dy + 1'b1 : r_dy;

   // Outputs are registered, so the pixel shown in a DRAW cycle is computed
   // one cycle earlier: from the queue head in LOAD (offset 0,0), otherwise
   // from the working request and the next offsets.
   assign w_src   = (r_state == S_LOAD) ? w_head : r_req;
   assign w_off_x = (r_state == S_LOAD) ? '0 : w_nx_dx;
   assign w_off_y = (r_state == S_LOAD) ? '0 : w_nx_dy;

   // One bit wider than the port so a box near the edge never wraps back
   // onto the visible screen.
   assign w_px  = (X_W+1)'(w_src.x) + (X_W+1)'(w_off_x);
   assign w_py  = (Y_W+1)'(w_src.y) + (Y_W+1)'(w_off_y);
   assign w_vis = (w_px <= (X_W+1)'(X_MAX)) && (w_py <= (Y_W+1)'(Y_MAX));

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_req        <= '0;
         r_dx         <= '0;
         r_dy         <= '0;
         r_vga_x      <= '0;
         r_vga_y      <= '0;
         r_vga_colour <= '0;
         r_plot       <= 1'b0;
         r_box_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_plot     <= 1'b0;
               r_box_done <= 1'b0;
               if (!w_empty) begin
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_req        <= w_head;
               r_dx         <= '0;
               r_dy         <= '0;
               r_vga_x      <= w_px[X_W-1:0];
               r_vga_y      <= w_py[Y_W-1:0];
               r_vga_colour <= w_head.colour;
               r_plot       <= w_vis;
               r_state      <= S_DRAW;
            end
            S_DRAW: begin
               if (w_last_col && w_last_row) begin
                  // vga_* keep the final pixel's values while not drawing.
                  r_plot     <= 1'b0;
                  r_box_done <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_dx         <= w_nx_dx;
                  r_dy         <= w_nx_dy;
                  r_vga_x      <= w_px[X_W-1:0];
                  r_vga_y      <= w_py[Y_W-1:0];
                  r_vga_colour <= r_req.colour;
                  r_plot       <= w_vis;
               end
            end
            S_DONE: begin
               r_box_done <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_plot     <= 1'b0;
               r_box_done <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   assign bus.req_ready  = !w_full && !reset;
   assign bus.busy       = (r_state != S_IDLE) || !w_empty;
   assign bus.vga_x      = r_vga_x;
   assign bus.vga_y      = r_vga_y;
   assign bus.vga_colour = r_vga_colour;
   assign bus.plot       = r_plot;
   assign bus.box_done   = r_box_done;
   assign bus.dbg_state  = r_state;
   assign bus.dbg_count  = DBG_CNT_W'(w_count);

endmodule : box_painter
